// File: rtl/gpca_op_sequencer.sv
// Command sequencer for the combinational gpca array: formats MUL/SQR/SQRT/DIV
// operands, normalises B/C one bit per cycle, drives the array, returns F/S.
module gpca_op_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [17:0] cmd_a,
   input  logic [8:0]  cmd_b,
   output logic        gp_x,
   output logic [8:0]  gp_p,
   output logic [17:0] gp_a,
   output logic [18:0] gp_b,
   output logic [18:0] gp_c,
   input  logic [8:0]  gp_f,
   input  logic [18:0] gp_s,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [8:0]  rsp_f,
   output logic [18:0] rsp_s,
   output logic        rsp_err,
   output logic [3:0]  rsp_shift
);

   localparam logic [1:0]  OP_MUL  = 2'b00;
   localparam logic [1:0]  OP_SQR  = 2'b01;
   localparam logic [1:0]  OP_SQRT = 2'b10;
   localparam logic [1:0]  OP_DIV  = 2'b11;
   localparam logic [18:0] SQ_B    = 19'b0011_1111_1111_1111_111;
   localparam logic [18:0] SQ_C    = 19'b0100_0000_0000_0000_000;
   localparam logic [4:0]  SETTLE_LAST = 5'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      NORM  = 2'b01,
      DRIVE = 2'b10,
      RESP  = 2'b11
   } state_t;

   state_t      state_r, state_s;
   logic        x_r, x_s;
   logic [8:0]  p_r, p_s;
   logic [17:0] a_r, a_s;
   logic [18:0] norm_r, norm_s;
   logic [4:0]  settle_r, settle_s;
   logic        gp_x_r, gp_x_s;
   logic [8:0]  gp_p_r, gp_p_s;
   logic [17:0] gp_a_r, gp_a_s;
   logic [18:0] gp_b_r, gp_b_s;
   logic [18:0] gp_c_r, gp_c_s;
   logic        cmd_ready_r, cmd_ready_s;
   logic        rsp_valid_r, rsp_valid_s;
   logic [8:0]  rsp_f_r, rsp_f_s;
   logic [18:0] rsp_s_r, rsp_s_s;
   logic        rsp_err_r, rsp_err_s;
   logic [3:0]  rsp_shift_r, rsp_shift_s;

   logic        dec_x_s;
   logic [8:0]  dec_p_s;
   logic [17:0] dec_a_s;
   logic        dec_norm_s;
   logic [8:0]  dec_val_s;
   logic [18:0] dec_b_s;
   logic [18:0] dec_c_s;

   // Operand decode of the offered command into array encoding.
   always_comb begin
      dec_x_s    = 1'b0;
      dec_p_s    = 9'd0;
      dec_a_s    = 18'd0;
      dec_norm_s = 1'b0;
      dec_val_s  = 9'd0;
      case (cmd_op)
         OP_MUL: begin
            dec_p_s    = cmd_b;
            dec_norm_s = 1'b1;
            dec_val_s  = cmd_a[8:0];
         end
         OP_SQR: begin
            dec_p_s = cmd_b;
         end
         OP_SQRT: begin
            dec_x_s = 1'b1;
            dec_a_s = cmd_a;
         end
         OP_DIV: begin
            dec_x_s    = 1'b1;
            dec_a_s    = cmd_a;
            dec_norm_s = 1'b1;
            dec_val_s  = cmd_b;
         end
         default: begin
            dec_x_s = 1'b0;
         end
      endcase
      if (dec_norm_s) begin
         dec_b_s = {dec_val_s, 10'd0};
         dec_c_s = {dec_val_s, 10'd0};
      end else begin
         dec_b_s = SQ_B;
         dec_c_s = SQ_C;
      end
   end

   // Next-state and next-register computation for the sequencer FSM.
   always_comb begin
      state_s     = state_r;
      x_s         = x_r;
      p_s         = p_r;
      a_s         = a_r;
      norm_s      = norm_r;
      settle_s    = settle_r;
      gp_x_s      = gp_x_r;
      gp_p_s      = gp_p_r;
      gp_a_s      = gp_a_r;
      gp_b_s      = gp_b_r;
      gp_c_s      = gp_c_r;
      cmd_ready_s = cmd_ready_r;
      rsp_valid_s = rsp_valid_r;
      rsp_f_s     = rsp_f_r;
      rsp_s_s     = rsp_s_r;
      rsp_err_s   = rsp_err_r;
      rsp_shift_s = rsp_shift_r;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               cmd_ready_s = 1'b0;
               rsp_f_s     = 9'd0;
               rsp_s_s     = 19'd0;
               rsp_err_s   = 1'b0;
               rsp_shift_s = 4'd0;
               settle_s    = 5'd0;
               x_s         = dec_x_s;
               p_s         = dec_p_s;
               a_s         = dec_a_s;
               norm_s      = dec_b_s;
               if (dec_norm_s && (dec_val_s == 9'd0)) begin
                  // Nothing to normalise: answer immediately with an error.
                  rsp_err_s   = 1'b1;
                  rsp_valid_s = 1'b1;
                  state_s     = RESP;
               end else if (dec_norm_s && !dec_val_s[8]) begin
                  state_s = NORM;
               end else begin
                  gp_x_s  = dec_x_s;
                  gp_p_s  = dec_p_s;
                  gp_a_s  = dec_a_s;
                  gp_b_s  = dec_b_s;
                  gp_c_s  = dec_c_s;
                  state_s = DRIVE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         NORM: begin
            norm_s      = {norm_r[17:0], 1'b0};
            rsp_shift_s = rsp_shift_r + 4'd1;
            // norm_r[17] becomes the MSB after this shift, so drive next.
            if (norm_r[17]) begin
               gp_x_s  = x_r;
               gp_p_s  = p_r;
               gp_a_s  = a_r;
               gp_b_s  = {norm_r[17:0], 1'b0};
               gp_c_s  = {norm_r[17:0], 1'b0};
               state_s = DRIVE;
            end else begin
               state_s = NORM;
            end
         end
         DRIVE: begin
            if (settle_r == SETTLE_LAST) begin
               rsp_f_s     = gp_f;
               rsp_s_s     = gp_s;
               rsp_valid_s = 1'b1;
               gp_x_s      = 1'b0;
               gp_p_s      = 9'd0;
               gp_a_s      = 18'd0;
               gp_b_s      = 19'd0;
               gp_c_s      = 19'd0;
               settle_s    = 5'd0;
               state_s     = RESP;
            end else begin
               settle_s = settle_r + 5'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_s = 1'b0;
               cmd_ready_s = 1'b1;
               state_s     = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s     = IDLE;
            cmd_ready_s = 1'b1;
            rsp_valid_s = 1'b0;
            gp_x_s      = 1'b0;
            gp_p_s      = 9'd0;
            gp_a_s      = 18'd0;
            gp_b_s      = 19'd0;
            gp_c_s      = 19'd0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         x_r         <= 1'b0;
         p_r         <= 9'd0;
         a_r         <= 18'd0;
         norm_r      <= 19'd0;
         settle_r    <= 5'd0;
         gp_x_r      <= 1'b0;
         gp_p_r      <= 9'd0;
         gp_a_r      <= 18'd0;
         gp_b_r      <= 19'd0;
         gp_c_r      <= 19'd0;
         cmd_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_f_r     <= 9'd0;
         rsp_s_r     <= 19'd0;
         rsp_err_r   <= 1'b0;
         rsp_shift_r <= 4'd0;
      end else begin
         state_r     <= state_s;
         x_r         <= x_s;
         p_r         <= p_s;
         a_r         <= a_s;
         norm_r      <= norm_s;
         settle_r    <= settle_s;
         gp_x_r      <= gp_x_s;
         gp_p_r      <= gp_p_s;
         gp_a_r      <= gp_a_s;
         gp_b_r      <= gp_b_s;
         gp_c_r      <= gp_c_s;
         cmd_ready_r <= cmd_ready_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_f_r     <= rsp_f_s;
         rsp_s_r     <= rsp_s_s;
         rsp_err_r   <= rsp_err_s;
         rsp_shift_r <= rsp_shift_s;
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign gp_x      = gp_x_r;
   assign gp_p      = gp_p_r;
   assign gp_a      = gp_a_r;
   assign gp_b      = gp_b_r;
   assign gp_c      = gp_c_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_f     = rsp_f_r;
   assign rsp_s     = rsp_s_r;
   assign rsp_err   = rsp_err_r;
   assign rsp_shift = rsp_shift_r;

endmodule

// File: tb/tb_gpca_op_sequencer.sv
// Directed testbench for gpca_op_sequencer; a small stand-in array model
// answers gp_* with F/S so captured results can be predicted.
module tb_gpca_op_sequencer;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [17:0] cmd_a;
   logic [8:0]  cmd_b;
   logic        gp_x;
   logic [8:0]  gp_p;
   logic [17:0] gp_a;
   logic [18:0] gp_b;
   logic [18:0] gp_c;
   logic [8:0]  gp_f;
   logic [18:0] gp_s;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [8:0]  rsp_f;
   logic [18:0] rsp_s;
   logic        rsp_err;
   logic [3:0]  rsp_shift;

   int total;
   int bad;

   localparam logic [18:0] SQ_B = 19'b0011_1111_1111_1111_111;
   localparam logic [18:0] SQ_C = 19'b0100_0000_0000_0000_000;

   gpca_op_sequencer #(.SETTLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .gp_x(gp_x), .gp_p(gp_p), .gp_a(gp_a), .gp_b(gp_b), .gp_c(gp_c),
      .gp_f(gp_f), .gp_s(gp_s),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_f(rsp_f), .rsp_s(rsp_s), .rsp_err(rsp_err), .rsp_shift(rsp_shift)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] mdl_f(input logic x, input logic [8:0] p, input logic [18:0] b);
      return p ^ b[18:10] ^ {8'd0, x};
   endfunction

   function automatic logic [18:0] mdl_s(input logic [17:0] a, input logic [18:0] b, input logic [18:0] c);
      return b ^ {c[17:0], 1'b0} ^ {1'b0, a};
   endfunction

   // Stand-in for the combinational array.
   always_comb begin
      gp_f = mdl_f(gp_x, gp_p, gp_b);
      gp_s = mdl_s(gp_a, gp_b, gp_c);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   function automatic logic gp_any();
      return gp_x || (gp_p != 9'd0) || (gp_a != 18'd0) || (gp_b != 19'd0) || (gp_c != 19'd0);
   endfunction

   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [17:0] a,
                          input logic [8:0] b, input int hold,
                          input logic ex, input logic [8:0] ep, input logic [17:0] ea,
                          input logic [18:0] eb, input logic [18:0] ec,
                          input int elat, input logic eerr, input logic [3:0] esh);
      int lat;
      int dcnt;
      logic        sx;
      logic [8:0]  sp;
      logic [17:0] sa;
      logic [18:0] sb;
      logic [18:0] sc;
      logic [8:0]  ef;
      logic [18:0] es;
      ef = eerr ? 9'd0 : mdl_f(ex, ep, eb);
      es = eerr ? 19'd0 : mdl_s(ea, eb, ec);
      sx = 1'b0; sp = 9'd0; sa = 18'd0; sb = 19'd0; sc = 19'd0;
      rsp_ready = (hold == 0);
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      check_eq({tag, ".rdy"}, 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat  = 1;
      dcnt = 0;
      while (!rsp_valid && lat < 100) begin
         if (gp_any()) begin
            dcnt++;
            sx = gp_x; sp = gp_p; sa = gp_a; sb = gp_b; sc = gp_c;
         end
         @(posedge clk); #1;
         lat++;
      end
      check_eq({tag, ".lat"},   32'(lat), 32'(elat));
      check_eq({tag, ".err"},   32'(rsp_err), 32'(eerr));
      check_eq({tag, ".f"},     32'(rsp_f), 32'(ef));
      check_eq({tag, ".s"},     32'(rsp_s), 32'(es));
      check_eq({tag, ".shift"}, 32'(rsp_shift), 32'(esh));
      check_eq({tag, ".drv"},   32'(dcnt), eerr ? 32'd0 : 32'd4);
      check_eq({tag, ".x"},     32'(sx), 32'(ex));
      check_eq({tag, ".p"},     32'(sp), 32'(ep));
      check_eq({tag, ".a"},     32'(sa), 32'(ea));
      check_eq({tag, ".b"},     32'(sb), 32'(eb));
      check_eq({tag, ".c"},     32'(sc), 32'(ec));
      check_eq({tag, ".gpoff"}, 32'(gp_any()), 32'd0);
      check_eq({tag, ".busy"},  32'(cmd_ready), 32'd0);
      if (hold > 0) begin
         cmd_op    = 2'b01;
         cmd_a     = 18'd0;
         cmd_b     = 9'd5;
         cmd_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({tag, ".hv"}, 32'(rsp_valid), 32'd1);
            check_eq({tag, ".hf"}, 32'(rsp_f), 32'(ef));
            check_eq({tag, ".hs"}, 32'(rsp_s), 32'(es));
            check_eq({tag, ".hrdy"}, 32'(cmd_ready), 32'd0);
         end
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      check_eq({tag, ".done"}, 32'(rsp_valid), 32'd0);
      check_eq({tag, ".idle"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int seen;
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_a     = 18'd0;
      cmd_b     = 9'd0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst.rdy",   32'(cmd_ready), 32'd1);
      check_eq("rst.valid", 32'(rsp_valid), 32'd0);
      check_eq("rst.gp",    32'(gp_any()), 32'd0);
      check_eq("rst.rsp",   32'({rsp_f, rsp_s, rsp_err, rsp_shift} != 33'd0), 32'd0);

      //       tag         op     a           b        hold x     p        a           b              c              lat err shift
      run_cmd("mul7x5",   2'b00, 18'd7,      9'd5,    0, 1'b0, 9'd5,   18'd0,      19'h70000,     19'h70000,     11, 1'b0, 4'd6);
      run_cmd("sqr5",     2'b01, 18'd0,      9'd5,    0, 1'b0, 9'd5,   18'd0,      SQ_B,          SQ_C,          5,  1'b0, 4'd0);
      run_cmd("sqrt25",   2'b10, 18'd25,     9'd0,    0, 1'b1, 9'd0,   18'd25,     SQ_B,          SQ_C,          5,  1'b0, 4'd0);
      run_cmd("div35z",   2'b11, 18'd35,     9'd0,    0, 1'b0, 9'd0,   18'd0,      19'd0,         19'd0,         1,  1'b1, 4'd0);
      run_cmd("div35b7",  2'b11, 18'd35,     9'd7,    0, 1'b1, 9'd0,   18'd35,     19'h70000,     19'h70000,     11, 1'b0, 4'd6);
      run_cmd("divmsb",   2'b11, 18'd1000,   9'h1A5,  0, 1'b1, 9'd0,   18'd1000,   {9'h1A5,10'd0},{9'h1A5,10'd0},5,  1'b0, 4'd0);
      run_cmd("mulhi",    2'b00, 18'h30003,  9'h1FF,  0, 1'b0, 9'h1FF, 18'd0,      19'h60000,     19'h60000,     12, 1'b0, 4'd7);
      run_cmd("mulz",     2'b00, 18'h3FE00,  9'd9,    0, 1'b0, 9'd0,   18'd0,      19'd0,         19'd0,         1,  1'b1, 4'd0);
      run_cmd("hold",     2'b00, 18'd7,      9'd5,    10, 1'b0, 9'd5,  18'd0,      19'h70000,     19'h70000,     11, 1'b0, 4'd6);
      run_cmd("sqrnext",  2'b01, 18'd0,      9'd5,    0, 1'b0, 9'd5,   18'd0,      SQ_B,          SQ_C,          5,  1'b0, 4'd0);

      // Abort a MUL a=1 while it is still normalising.
      cmd_op    = 2'b00;
      cmd_a     = 18'd1;
      cmd_b     = 9'd3;
      cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("abort.busy", 32'(cmd_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort.rdy",   32'(cmd_ready), 32'd1);
      check_eq("abort.gp",    32'(gp_any()), 32'd0);
      check_eq("abort.valid", 32'(rsp_valid), 32'd0);
      check_eq("abort.shift", 32'(rsp_shift), 32'd0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (rsp_valid || gp_any()) seen++;
      end
      check_eq("abort.quiet", 32'(seen), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
